truth_table_extractor: RTL and testbench
========================================

# truth_table_extractor

Sequential characterizer that drives every input combination into an attached combinational N-input/M-output logic block, samples the block's response per row, and packs the result into one truth-table word handed to a consumer over a valid/ready handshake. It is the counterpart to the team's truth-table logic modules: those map a case-table to outputs, this block recovers the table from a live implementation. It sits between a synthesized logic netlist under test and the netlist-comparison/readback path.

## Interface

Parameters:
- N_IN, 3, number of inputs of the attached function; ROWS = 2**N_IN.
- N_OUT, 2, number of outputs of the attached function.
- SETTLE, 1, cycles the stimulus is held before sampling; legal range 1..15.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a sweep; honoured only in IDLE.
- stim_out  output  N_IN  stimulus to the function, packed {inN..in1}; row index r drives stim_out = r.
- resp_in  input  N_OUT  function response, packed {out1..outM}; out1 is the MSB.
- table_out  output  ROWS*N_OUT  row r stored at table_out[r*N_OUT +: N_OUT].
- table_valid  output  1  table_out complete and stable.
- table_ready  input  1  consumer accepts table when high with table_valid.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the table is accepted.

## Operation

- States: IDLE, WAIT, SAMPLE, PRESENT.
- IDLE: stim_out = 0. When start = 1: clear table_out to 0, row <= 0, settle counter <= 0, go to WAIT.
- WAIT: stim_out = row. The counter increments each cycle; after SETTLE cycles in WAIT, go to SAMPLE.
- SAMPLE: capture resp_in into row slot `row`.
  - If row == ROWS-1, go to PRESENT.
  - Otherwise row <= row+1, counter <= 0, go to WAIT.
- PRESENT: table_valid = 1 and table_out holds stable. When table_ready = 1, go to IDLE and assert done the next cycle. table_out retains its contents in IDLE until the next start.
- start while busy: ignored with no side effects.
- table_ready outside PRESENT: ignored.
- Row counter width: N_IN+1 bits, so no wrap at ROWS-1 when N_IN is maximal.
- resp_in is treated as combinational from stim_out; no synchronizer.

## Timing

- Reset values: stim_out = 0, table_out = 0, table_valid = 0, busy = 0, done = 0, state = IDLE. Reset mid-sweep or in PRESENT aborts immediately and discards the partial table.
- Cycle 0: start sampled high in IDLE.
- Cycle 1: first WAIT cycle; stim_out = 0 and busy = 1.
- Row r is sampled at cycle 1 + (SETTLE+1)*r + SETTLE.
- table_valid first high at cycle 1 + (SETTLE+1)*ROWS. Defaults: cycle 17.
- Handshake completes on the first cycle with table_valid & table_ready.
  - Next cycle: IDLE, table_valid = 0, busy = 0, done = 1 for exactly one cycle.
- start sampled in the same cycle done is high is accepted, since the state is IDLE.
- Back-to-back sweep period with ready held high: (SETTLE+1)*ROWS + 2 cycles.

## Structure

- Shared package truth_table_pkg:
  - state enum {IDLE, WAIT, SAMPLE, PRESENT}.
  - ROWS and table-width localparam helpers.
  - Row slice macro/function, reused by the comparison block.
- Single module; no sub-module needed. The settle counter and row counter stay inline.

## Test plan

- Golden function with defaults, rows 0..7 = 01,10,11,01,01,10,11,00; start pulse, ready held high → table_valid at cycle 17, table_out = 16'h3979, done pulse at cycle 18.
- Constant function resp_in = 2'b11 with SETTLE = 3 → table_out = 16'hFFFF and table_valid at cycle 33; stim_out holds each row for 3 WAIT cycles + 1 SAMPLE cycle.
- Backpressure: table_ready low for 10 cycles in PRESENT → table_out stable at 16'h3979, busy = 1, done = 0 throughout; ready high → done the cycle after.
- start re-pulsed at cycles 5 and 17 during a sweep → ignored; table identical to the single-start result.
- rst asserted at cycle 9 mid-sweep → next cycle all outputs at reset values; fresh start yields 16'h3979.
- start asserted in the same cycle as done → second sweep begins, stim_out = 0 next cycle, second table_valid 18 cycles after the first handshake.

Source files
------------

// File: rtl/truth_table_pkg.sv
// ----------------------------------------------------------------------------
// truth_table_pkg
//   Shared definitions for the truth-table extractor and the blocks that
//   consume or compare its packed table word.
//   - state_e       : sweep controller states
//   - SETTLE_W      : width of the settle counter (SETTLE is 1..15)
//   - rows_of       : number of rows for an N-input function (2**N)
//   - table_width   : packed table width for N inputs / M outputs
//   - row_lsb       : bit offset of row r inside a packed table word
// ----------------------------------------------------------------------------
package truth_table_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        SAMPLE  = 2'd2,
        PRESENT = 2'd3
    } state_e;

    localparam int SETTLE_W = 4;

    function automatic int rows_of(input int n_in);
        return 1 << n_in;
    endfunction

    function automatic int table_width(input int n_in, input int n_out);
        return rows_of(n_in) * n_out;
    endfunction

    // Row r occupies table[row_lsb(r, n_out) +: n_out].
    function automatic int row_lsb(input int row, input int n_out);
        return row * n_out;
    endfunction

endpackage

// File: rtl/truth_table_extractor.sv
// ----------------------------------------------------------------------------
// truth_table_extractor
//   Sweeps every input combination of an attached combinational block,
//   holds each one for SETTLE cycles, samples the response and packs the
//   rows into a single table word offered over a valid/ready handshake.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   start        in   begin a sweep (honoured only in IDLE)
//   stim_out     out  [N_IN]       stimulus, row index r drives r
//   resp_in      in   [N_OUT]      response of the attached function
//   table_out    out  [ROWS*N_OUT] row r at [r*N_OUT +: N_OUT]
//   table_valid  out  table complete and stable (PRESENT)
//   table_ready  in   consumer accepts the table
//   busy         out  high whenever not IDLE
//   done         out  one-cycle pulse after the table is accepted
// ----------------------------------------------------------------------------
module truth_table_extractor
    import truth_table_pkg::*;
#(
    parameter  int N_IN   = 3,
    parameter  int N_OUT  = 2,
    parameter  int SETTLE = 1,
    localparam int ROWS   = rows_of(N_IN),
    localparam int TBL_W  = table_width(N_IN, N_OUT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [N_IN-1:0]   stim_out,
    input  logic [N_OUT-1:0]  resp_in,
    output logic [TBL_W-1:0]  table_out,
    output logic              table_valid,
    input  logic              table_ready,
    output logic              busy,
    output logic              done
);

    // One extra bit so the last row index never aliases row 0.
    localparam int                    ROW_W       = N_IN + 1;
    localparam logic [ROW_W-1:0]      LAST_ROW    = ROW_W'(ROWS - 1);
    localparam logic [SETTLE_W-1:0]   SETTLE_LAST = SETTLE_W'(SETTLE - 1);

    state_e                state_q, state_d;
    logic [ROW_W-1:0]      row_q,   row_d;
    logic [SETTLE_W-1:0]   cnt_q,   cnt_d;
    logic [TBL_W-1:0]      table_q, table_d;
    logic                  done_q,  done_d;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: non-blocking assignments here so every flop samples the values
    // of the previous cycle, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            cnt_q   <= '0;
            // NOTE: the table register is reset because it drives a port
            // whose reset value is observable; it is a flop bank, not a RAM.
            table_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            table_q <= table_d;
            done_q  <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would infer a latch.
        state_d = state_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        table_d = table_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    table_d = '0;
                    row_d   = '0;
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end

            WAIT: begin
                // Stimulus has been applied for SETTLE cycles once the
                // counter reaches SETTLE-1.
                if (cnt_q == SETTLE_LAST) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            SAMPLE: begin
                table_d[row_lsb(int'(row_q), N_OUT) +: N_OUT] = resp_in;
                if (row_q == LAST_ROW) begin
                    state_d = PRESENT;
                end else begin
                    row_d   = row_q + 1'b1;
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end

            PRESENT: begin
                if (table_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        stim_out    = '0;
        busy        = (state_q != IDLE);
        table_valid = (state_q == PRESENT);
        table_out   = table_q;
        done        = done_q;
        // The row stays on the stimulus through SAMPLE so the sampled
        // response belongs to the same row.
        if (state_q == WAIT || state_q == SAMPLE) begin
            stim_out = row_q[N_IN-1:0];
        end
    end

endmodule

// File: tb/tb_truth_table_extractor.sv
// ----------------------------------------------------------------------------
// tb_truth_table_extractor
//   Self-checking bench for truth_table_extractor. Two instances: default
//   parameters (golden / alternate function) and SETTLE = 3 (constant 11).
//   Expected tables are pushed to a scoreboard queue when a sweep is started
//   and popped when table_valid is observed.
// ----------------------------------------------------------------------------
module tb_truth_table_extractor;
    import truth_table_pkg::*;

    localparam int TBL_W = 16;
    localparam int BUDGET = 200;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Instance A: defaults
    logic               start_a, ready_a, valid_a, busy_a, done_a;
    logic [2:0]         stim_a;
    logic [1:0]         resp_a;
    logic [TBL_W-1:0]   table_a;

    // Instance B: SETTLE = 3
    logic               start_b, ready_b, valid_b, busy_b, done_b;
    logic [2:0]         stim_b;
    logic [1:0]         resp_b;
    logic [TBL_W-1:0]   table_b;

    int checks   = 0;
    int failures = 0;
    int func_sel = 0;

    logic [TBL_W-1:0] exp_q[$];

    // Reference functions attached to instance A.
    // sel 0: golden rows 0..7 = 01,10,11,01,01,10,11,00
    // sel 1: (3*r + 1) mod 4
    function automatic logic [1:0] ref_func(input int sel, input int r);
        if (sel == 0) begin
            case (r)
                0: return 2'b01;
                1: return 2'b10;
                2: return 2'b11;
                3: return 2'b01;
                4: return 2'b01;
                5: return 2'b10;
                6: return 2'b11;
                default: return 2'b00;
            endcase
        end
        return 2'((3 * r) + 1);
    endfunction

    function automatic logic [TBL_W-1:0] model_table(input int sel);
        logic [TBL_W-1:0] t;
        t = '0;
        for (int r = 0; r < 8; r++) t[r*2 +: 2] = ref_func(sel, r);
        return t;
    endfunction

    assign resp_a = ref_func(func_sel, int'(stim_a));
    assign resp_b = 2'b11;

    truth_table_extractor #(.N_IN(3), .N_OUT(2), .SETTLE(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a),
        .stim_out(stim_a), .resp_in(resp_a),
        .table_out(table_a), .table_valid(valid_a), .table_ready(ready_a),
        .busy(busy_a), .done(done_a)
    );

    truth_table_extractor #(.N_IN(3), .N_OUT(2), .SETTLE(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b),
        .stim_out(stim_b), .resp_in(resp_b),
        .table_out(table_b), .table_valid(valid_b), .table_ready(ready_b),
        .busy(busy_b), .done(done_b)
    );

    // Starts a sweep on A: start sampled at edge "cycle 0"; returns at the
    // negedge of cycle 1.
    task automatic launch_a(input int sel);
        @(negedge clk);
        start_a = 1'b1;
        exp_q.push_back(model_table(sel));
        @(negedge clk);
        start_a = 1'b0;
    endtask

    // Waits (bounded) for valid on A; c is the current cycle number.
    task automatic wait_valid_a(inout int c);
        while (!valid_a && c < BUDGET) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (stim_a !== 3'd0 || table_a !== 16'h0 || valid_a !== 1'b0 ||
            busy_a !== 1'b0 || done_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_a got stim=%h tbl=%h v=%b b=%b d=%b want all 0",
                     stim_a, table_a, valid_a, busy_a, done_a);
        end
        checks++;
        if (stim_b !== 3'd0 || table_b !== 16'h0 || valid_b !== 1'b0 ||
            busy_b !== 1'b0 || done_b !== 1'b0) begin
            failures++;
            $display("FAIL reset_b got stim=%h tbl=%h v=%b b=%b d=%b want all 0",
                     stim_b, table_b, valid_b, busy_b, done_b);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_golden;
        int c;
        int bad_stim;
        logic [TBL_W-1:0] exp;
        func_sel = 0;
        ready_a  = 1'b1;
        launch_a(0);
        c = 1;
        bad_stim = 0;
        while (!valid_a && c < BUDGET) begin
            if (stim_a !== 3'((c - 1) / 2) || busy_a !== 1'b1) bad_stim++;
            @(negedge clk);
            c++;
        end
        checks++;
        if (bad_stim != 0) begin
            failures++;
            $display("FAIL golden_stim got %0d bad cycles want 0", bad_stim);
        end
        checks++;
        if (c != 17) begin
            failures++;
            $display("FAIL golden_valid_cycle got=%0d want=17", c);
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        checks++;
        if (table_a !== exp) begin
            failures++;
            $display("FAIL golden_table got=%h want=%h", table_a, exp);
        end
        checks++;
        if (table_a !== 16'h3979) begin
            failures++;
            $display("FAIL golden_literal got=%h want=3979", table_a);
        end
        @(negedge clk);
        checks++;
        if (done_a !== 1'b1 || valid_a !== 1'b0 || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL golden_done got d=%b v=%b b=%b want d=1 v=0 b=0",
                     done_a, valid_a, busy_a);
        end
        @(negedge clk);
        checks++;
        if (done_a !== 1'b0 || table_a !== 16'h3979) begin
            failures++;
            $display("FAIL golden_idle got d=%b tbl=%h want d=0 tbl=3979",
                     done_a, table_a);
        end
    endtask

    task automatic test_settle3;
        int c;
        int bad_stim;
        logic [TBL_W-1:0] exp;
        ready_b = 1'b1;
        @(negedge clk);
        start_b = 1'b1;
        exp_q.push_back(16'hFFFF);
        @(negedge clk);
        start_b = 1'b0;
        c = 1;
        bad_stim = 0;
        while (!valid_b && c < BUDGET) begin
            if (stim_b !== 3'((c - 1) / 4) || busy_b !== 1'b1) bad_stim++;
            @(negedge clk);
            c++;
        end
        checks++;
        if (bad_stim != 0) begin
            failures++;
            $display("FAIL settle3_stim got %0d bad cycles want 0", bad_stim);
        end
        checks++;
        if (c != 33) begin
            failures++;
            $display("FAIL settle3_valid_cycle got=%0d want=33", c);
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        checks++;
        if (table_b !== exp) begin
            failures++;
            $display("FAIL settle3_table got=%h want=%h", table_b, exp);
        end
        @(negedge clk);
        checks++;
        if (done_b !== 1'b1) begin
            failures++;
            $display("FAIL settle3_done got=%b want=1", done_b);
        end
    endtask

    task automatic test_backpressure;
        int c;
        int bad;
        logic [TBL_W-1:0] exp;
        func_sel = 0;
        ready_a  = 1'b0;
        launch_a(0);
        c = 1;
        wait_valid_a(c);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (table_a !== exp || valid_a !== 1'b1 || busy_a !== 1'b1 ||
                done_a !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0 || exp !== 16'h3979) begin
            failures++;
            $display("FAIL backpressure_hold got %0d bad cycles tbl=%h want 0 bad tbl=3979",
                     bad, table_a);
        end
        ready_a = 1'b1;
        @(negedge clk);
        checks++;
        if (done_a !== 1'b1 || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_done got d=%b b=%b want d=1 b=0",
                     done_a, busy_a);
        end
        @(negedge clk);
    endtask

    task automatic test_start_ignored;
        int vc;
        int bad_idle;
        logic [TBL_W-1:0] exp;
        func_sel = 0;
        ready_a  = 1'b1;
        launch_a(0);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        vc = -1;
        bad_idle = 0;
        for (int c = 1; c <= 22; c++) begin
            start_a = (c == 5 || c == 17);
            if (valid_a === 1'b1 && vc < 0) vc = c;
            if (c == 17) begin
                checks++;
                if (table_a !== exp) begin
                    failures++;
                    $display("FAIL restart_table got=%h want=%h", table_a, exp);
                end
            end
            if (c >= 19 && busy_a !== 1'b0) bad_idle++;
            @(negedge clk);
        end
        start_a = 1'b0;
        checks++;
        if (vc != 17) begin
            failures++;
            $display("FAIL restart_valid_cycle got=%0d want=17", vc);
        end
        checks++;
        if (bad_idle != 0) begin
            failures++;
            $display("FAIL restart_idle got %0d busy cycles want 0", bad_idle);
        end
    endtask

    task automatic test_reset_mid;
        int c;
        logic [TBL_W-1:0] exp;
        func_sel = 0;
        ready_a  = 1'b1;
        launch_a(0);
        for (c = 1; c < 9; c++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (stim_a !== 3'd0 || table_a !== 16'h0 || valid_a !== 1'b0 ||
            busy_a !== 1'b0 || done_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid got stim=%h tbl=%h v=%b b=%b d=%b want all 0",
                     stim_a, table_a, valid_a, busy_a, done_a);
        end
        exp_q.delete();
        rst = 1'b0;
        launch_a(0);
        c = 1;
        wait_valid_a(c);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        checks++;
        if (c != 17 || table_a !== exp) begin
            failures++;
            $display("FAIL reset_mid_resweep got cyc=%0d tbl=%h want cyc=17 tbl=%h",
                     c, table_a, exp);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int c;
        logic [TBL_W-1:0] exp;
        func_sel = 0;
        ready_a  = 1'b1;
        launch_a(0);
        c = 1;
        wait_valid_a(c);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        checks++;
        if (c != 17 || table_a !== exp) begin
            failures++;
            $display("FAIL b2b_first got cyc=%0d tbl=%h want cyc=17 tbl=%h",
                     c, table_a, exp);
        end
        @(negedge clk);
        c++;
        checks++;
        if (done_a !== 1'b1) begin
            failures++;
            $display("FAIL b2b_done1 got=%b want=1", done_a);
        end
        // start coincides with done; switch the attached function too.
        start_a  = 1'b1;
        func_sel = 1;
        exp_q.push_back(model_table(1));
        @(negedge clk);
        c++;
        start_a = 1'b0;
        checks++;
        if (stim_a !== 3'd0 || busy_a !== 1'b1) begin
            failures++;
            $display("FAIL b2b_restart got stim=%h busy=%b want stim=0 busy=1",
                     stim_a, busy_a);
        end
        wait_valid_a(c);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        checks++;
        if (c != 35) begin
            failures++;
            $display("FAIL b2b_period got cyc=%0d want=35", c);
        end
        checks++;
        if (table_a !== exp) begin
            failures++;
            $display("FAIL b2b_second_table got=%h want=%h", table_a, exp);
        end
        @(negedge clk);
        checks++;
        if (done_a !== 1'b1) begin
            failures++;
            $display("FAIL b2b_done2 got=%b want=1", done_a);
        end
        func_sel = 0;
        @(negedge clk);
    endtask

    initial begin
        rst     = 1'b1;
        start_a = 1'b0;
        ready_a = 1'b0;
        start_b = 1'b0;
        ready_b = 1'b0;
        test_reset();
        test_golden();
        test_settle3();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
